// File: rtl/pcie_pio_regs_if.sv
// PIO request / read-completion bus between the TLP engines and the register file.
// The master side is the TLP engine pair; the slave side is pcie_pio_regs.
interface pcie_pio_regs_if;
  logic        pio_write_valid;
  logic        pio_read_valid;
  logic [12:0] pio_address;
  logic [63:0] pio_write_data;
  logic [23:0] pio_rid_tag;
  logic        cpl_valid;
  logic [23:0] cpl_rid_tag;
  logic [3:0]  cpl_lower_addr;
  logic [63:0] cpl_data;

  modport master (
    output pio_write_valid, pio_read_valid, pio_address, pio_write_data, pio_rid_tag,
    input  cpl_valid, cpl_rid_tag, cpl_lower_addr, cpl_data
  );

  modport slave (
    input  pio_write_valid, pio_read_valid, pio_address, pio_write_data, pio_rid_tag,
    output cpl_valid, cpl_rid_tag, cpl_lower_addr, cpl_data
  );
endinterface

// File: rtl/pcie_pio_regs.sv
// PIO register file with read-to-clear interrupt latch, MSI request FSM with holdoff
// coalescing, and a two-stage pipelined read completion path.
module pcie_pio_regs #(
  parameter int NIRQ    = 3,
  parameter int NSTATUS = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  pcie_pio_regs_if.slave            pio,
  input  logic                      completion_valid,
  input  logic [NIRQ-1:0]           irq_in,
  input  logic [(NSTATUS > 0 ? 64*NSTATUS : 64)-1:0] status_in,
  output logic                      cfg_interrupt,
  input  logic                      cfg_interrupt_rdy,
  output logic [NIRQ-1:0]           irq_enable
);
  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t state_q, state_d;
  logic [15:0] hold_cnt_q, hold_cnt_d;
  logic [NIRQ-1:0] irq_latch_q, irq_latch_d, irq_enable_q, irq_enable_d, irq_clr;
  logic [15:0] holdoff_q, holdoff_d;
  logic [15:0] cpl_count_q, cpl_count_d, write_count_q, write_count_d;
  logic [15:0] read_count_q, read_count_d;
  logic irq_pending_q, irq_pending_d, irq_accept;
  logic rd_valid_q, rd_valid_d;
  logic [23:0] rd_tag_q, rd_tag_d;
  logic [3:0]  rd_lo_q, rd_lo_d;
  logic [63:0] rd_data_q, rd_data_d, rdata;
  logic cpl_valid_q, cpl_valid_d;
  logic [23:0] cpl_rid_tag_q, cpl_rid_tag_d;
  logic [3:0]  cpl_lower_addr_q, cpl_lower_addr_d;
  logic [63:0] cpl_data_q, cpl_data_d;
  logic unused_wdata;

  assign unused_wdata = ^pio.pio_write_data;

  always_comb begin
    rdata = 64'h0;
    case (pio.pio_address)
      13'd0: rdata = 64'(irq_latch_q);
      13'd1: rdata = 64'(irq_enable_q);
      13'd2: rdata = {16'h0, cpl_count_q, write_count_q, read_count_q};
      13'd3: rdata = {48'h0, holdoff_q};
      default: begin
        for (int k = 0; k < NSTATUS; k++) begin
          if (pio.pio_address == 13'(8 + k)) rdata = status_in[64*k +: 64];
        end
      end
    endcase
  end

  assign irq_accept = (state_q == REQ) && cfg_interrupt_rdy;

  always_comb begin
    // The cleared mask is exactly what the read returns, so same-cycle arrivals survive.
    irq_clr       = (pio.pio_read_valid && pio.pio_address == 13'd0) ? irq_latch_q : '0;
    irq_latch_d   = (irq_latch_q & ~irq_clr) | irq_in;
    irq_enable_d  = irq_enable_q;
    holdoff_d     = holdoff_q;
    if (pio.pio_write_valid && pio.pio_address == 13'd1) irq_enable_d = pio.pio_write_data[NIRQ-1:0];
    if (pio.pio_write_valid && pio.pio_address == 13'd3) holdoff_d = pio.pio_write_data[15:0];
    cpl_count_d   = cpl_count_q + 16'(completion_valid);
    write_count_d = write_count_q + 16'(pio.pio_write_valid);
    read_count_d  = read_count_q + 16'(pio.pio_read_valid);
    irq_pending_d = (|(irq_in & irq_enable_q)) | (irq_pending_q & ~irq_accept);

    rd_valid_d = pio.pio_read_valid;
    rd_tag_d   = pio.pio_read_valid ? pio.pio_rid_tag : rd_tag_q;
    rd_lo_d    = pio.pio_read_valid ? pio.pio_address[3:0] : rd_lo_q;
    rd_data_d  = pio.pio_read_valid ? rdata : rd_data_q;

    cpl_valid_d      = rd_valid_q;
    cpl_rid_tag_d    = rd_valid_q ? rd_tag_q : cpl_rid_tag_q;
    cpl_lower_addr_d = rd_valid_q ? rd_lo_q : cpl_lower_addr_q;
    cpl_data_d       = rd_valid_q ? rd_data_q : cpl_data_q;
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      IDLE: if (irq_pending_q) state_d = REQ;
      REQ: begin
        if (cfg_interrupt_rdy) begin
          hold_cnt_d = holdoff_q;
          state_d    = (holdoff_q != 16'd0) ? HOLD : IDLE;
        end
      end
      HOLD: begin
        hold_cnt_d = hold_cnt_q - 16'd1;
        if (hold_cnt_q == 16'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      hold_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  always_comb begin
    cfg_interrupt = (state_q == REQ);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      irq_latch_q      <= '0;
      irq_enable_q     <= '0;
      holdoff_q        <= 16'd0;
      cpl_count_q      <= 16'd0;
      write_count_q    <= 16'd0;
      read_count_q     <= 16'd0;
      irq_pending_q    <= 1'b0;
      rd_valid_q       <= 1'b0;
      rd_tag_q         <= 24'd0;
      rd_lo_q          <= 4'd0;
      rd_data_q        <= 64'd0;
      cpl_valid_q      <= 1'b0;
      cpl_rid_tag_q    <= 24'd0;
      cpl_lower_addr_q <= 4'd0;
      cpl_data_q       <= 64'd0;
    end else begin
      irq_latch_q      <= irq_latch_d;
      irq_enable_q     <= irq_enable_d;
      holdoff_q        <= holdoff_d;
      cpl_count_q      <= cpl_count_d;
      write_count_q    <= write_count_d;
      read_count_q     <= read_count_d;
      irq_pending_q    <= irq_pending_d;
      rd_valid_q       <= rd_valid_d;
      rd_tag_q         <= rd_tag_d;
      rd_lo_q          <= rd_lo_d;
      rd_data_q        <= rd_data_d;
      cpl_valid_q      <= cpl_valid_d;
      cpl_rid_tag_q    <= cpl_rid_tag_d;
      cpl_lower_addr_q <= cpl_lower_addr_d;
      cpl_data_q       <= cpl_data_d;
    end
  end

  assign irq_enable         = irq_enable_q;
  assign pio.cpl_valid      = cpl_valid_q;
  assign pio.cpl_rid_tag    = cpl_rid_tag_q;
  assign pio.cpl_lower_addr = cpl_lower_addr_q;
  assign pio.cpl_data       = cpl_data_q;
endmodule

// File: tb/tb_pcie_pio_regs.sv
// Scoreboard bench for pcie_pio_regs: reads push expected completions, a negedge
// monitor pops and compares them; interrupt timing is checked inline.
module tb_pcie_pio_regs;
  logic clk = 1'b0;
  logic rst;
  logic completion_valid;
  logic [2:0] irq_in;
  logic [127:0] status_in;
  logic cfg_interrupt, cfg_interrupt_rdy;
  logic [2:0] irq_enable;
  int cyc = 0;
  int n_cmp = 0, n_err = 0;
  int m_rd = 0, m_wr = 0, m_cpl = 0;

  typedef struct {
    logic [23:0] tag;
    logic [3:0]  lo;
    logic [63:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];

  pcie_pio_regs_if bus();

  pcie_pio_regs #(.NIRQ(3), .NSTATUS(2)) dut (
    .clock(clk), .reset(rst), .pio(bus.slave), .completion_valid(completion_valid),
    .irq_in(irq_in), .status_in(status_in), .cfg_interrupt(cfg_interrupt),
    .cfg_interrupt_rdy(cfg_interrupt_rdy), .irq_enable(irq_enable)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (bus.cpl_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_cpl", 64'(bus.cpl_valid), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("cpl tag=%h lo=%h data=%h cycle=%0d", bus.cpl_rid_tag, bus.cpl_lower_addr, bus.cpl_data, cyc);
        check("cpl_tag", 64'(bus.cpl_rid_tag), 64'(e.tag));
        check("cpl_lower_addr", 64'(bus.cpl_lower_addr), 64'(e.lo));
        check("cpl_data", bus.cpl_data, e.data);
        check("cpl_latency", 64'(cyc), 64'(e.due));
      end
    end
  end

  task automatic do_read(input logic [12:0] a, input logic [23:0] tag, input logic [63:0] exp);
    exp_t e;
    bus.pio_read_valid = 1'b1;
    bus.pio_address    = a;
    bus.pio_rid_tag    = tag;
    e.tag = tag; e.lo = a[3:0]; e.data = exp; e.due = cyc + 2;
    sb.push_back(e);
    m_rd++;
    tick();
    bus.pio_read_valid = 1'b0;
  endtask

  task automatic do_write(input logic [12:0] a, input logic [63:0] d);
    bus.pio_write_valid = 1'b1;
    bus.pio_address     = a;
    bus.pio_write_data  = d;
    m_wr++;
    $display("write addr=%0d data=%h cycle=%0d", a, d, cyc);
    tick();
    bus.pio_write_valid = 1'b0;
  endtask

  function automatic logic [63:0] counts();
    return {16'h0, 16'(m_cpl), 16'(m_wr), 16'(m_rd)};
  endfunction

  task automatic wait_cfg(input string name, input int limit, output int k);
    k = 0;
    while (!cfg_interrupt && k < limit) begin
      tick();
      k++;
    end
    if (!cfg_interrupt) check(name, 64'(cfg_interrupt), 64'd1);
  endtask

  task automatic rdy_and_measure(input string name, input int exp_gap);
    int k;
    cfg_interrupt_rdy = 1'b1;
    tick();
    cfg_interrupt_rdy = 1'b0;
    check({name, "_drop"}, 64'(cfg_interrupt), 64'd0);
    k = 1;
    while (!cfg_interrupt && k < 50) begin
      tick();
      k++;
    end
    check({name, "_gap"}, 64'(k), 64'(exp_gap));
  endtask

  initial begin
    int k;
    rst = 1'b1;
    bus.pio_write_valid = 1'b0; bus.pio_read_valid = 1'b0;
    bus.pio_address = '0; bus.pio_write_data = '0; bus.pio_rid_tag = '0;
    completion_valid = 1'b0; irq_in = '0; cfg_interrupt_rdy = 1'b0;
    status_in = {64'h5A, 64'hA5};
    repeat (3) tick();
    check("rst_cfg_interrupt", 64'(cfg_interrupt), 64'd0);
    check("rst_cpl_valid", 64'(bus.cpl_valid), 64'd0);
    check("rst_cpl_data", bus.cpl_data, 64'd0);
    check("rst_cpl_tag", 64'(bus.cpl_rid_tag), 64'd0);
    check("rst_irq_enable", 64'(irq_enable), 64'd0);
    rst = 1'b0;
    tick();

    // back-to-back reads after reset, then the counter register
    do_read(13'd0, 24'h000100, 64'd0);
    do_read(13'd1, 24'h000101, 64'd0);
    do_read(13'd3, 24'h000103, 64'd0);
    do_read(13'd5, 24'hABC105, 64'd0);
    do_read(13'd2, 24'h000102, 64'h4);
    repeat (3) tick();

    // enabled source raises a request; disabled source only latches
    do_write(13'd1, 64'h5);
    check("irq_enable_written", 64'(irq_enable), 64'h5);
    irq_in = 3'b001;
    tick();
    irq_in = 3'b000;
    check("irq_lat_t1", 64'(cfg_interrupt), 64'd0);
    tick();
    check("irq_lat_t2", 64'(cfg_interrupt), 64'd1);
    repeat (3) tick();
    check("irq_held", 64'(cfg_interrupt), 64'd1);
    cfg_interrupt_rdy = 1'b1;
    tick();
    cfg_interrupt_rdy = 1'b0;
    check("irq_drop_after_rdy", 64'(cfg_interrupt), 64'd0);
    irq_in = 3'b010;
    tick();
    irq_in = 3'b000;
    repeat (4) tick();
    check("disabled_no_req", 64'(cfg_interrupt), 64'd0);
    do_read(13'd0, 24'h000200, 64'h3);
    do_read(13'd0, 24'h000201, 64'h0);

    // clear does not lose a source arriving in the read cycle
    do_write(13'd1, 64'h0);
    irq_in = 3'b001;
    tick();
    irq_in = 3'b100;
    do_read(13'd0, 24'h000300, 64'h1);
    irq_in = 3'b000;
    do_read(13'd0, 24'h000301, 64'h4);
    do_read(13'd0, 24'h000302, 64'h0);

    // enabling over an already latched bit must not raise a request
    irq_in = 3'b010;
    tick();
    irq_in = 3'b000;
    do_write(13'd1, 64'h7);
    repeat (5) tick();
    check("enable_no_req", 64'(cfg_interrupt), 64'd0);
    do_read(13'd0, 24'h000400, 64'h2);

    // completion counter
    repeat (3) begin
      completion_valid = 1'b1;
      m_cpl++;
      tick();
    end
    completion_valid = 1'b0;
    do_read(13'd2, 24'h000500, counts());

    // holdoff coalescing with sources pulsing every cycle
    do_write(13'd3, 64'd10);
    do_read(13'd3, 24'h000600, 64'd10);
    irq_in = 3'b111;
    wait_cfg("holdoff_first_req", 10, k);
    rdy_and_measure("holdoff10_a", 12);
    rdy_and_measure("holdoff10_b", 12);
    do_write(13'd3, 64'd0);
    rdy_and_measure("holdoff0", 2);
    irq_in = 3'b000;
    cfg_interrupt_rdy = 1'b1;
    tick();
    cfg_interrupt_rdy = 1'b0;
    repeat (4) tick();
    check("idle_after_last_rdy", 64'(cfg_interrupt), 64'd0);
    do_read(13'd0, 24'h000700, 64'h7);
    do_read(13'd2, 24'h000701, counts());

    // status words and unmapped addresses
    do_read(13'd8, 24'h000800, 64'hA5);
    do_read(13'd9, 24'h000801, 64'h5A);
    do_read(13'd10, 24'h000802, 64'h0);
    do_read(13'd4, 24'h000803, 64'h0);
    do_read(13'h1FFF, 24'h000804, 64'h0);
    repeat (3) tick();

    // reset while a request is up and a read is in flight
    irq_in = 3'b001;
    tick();
    irq_in = 3'b000;
    wait_cfg("pre_reset_req", 10, k);
    bus.pio_read_valid = 1'b1;
    bus.pio_address    = 13'd0;
    bus.pio_rid_tag    = 24'hDEAD00;
    tick();
    bus.pio_read_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("reset_cfg_drop", 64'(cfg_interrupt), 64'd0);
    check("reset_no_cpl", 64'(bus.cpl_valid), 64'd0);
    tick();
    rst = 1'b0;
    check("reset_enable", 64'(irq_enable), 64'd0);
    m_rd = 0; m_wr = 0; m_cpl = 0;
    tick();
    do_read(13'd0, 24'h000900, 64'h0);
    repeat (3) tick();
    check("post_reset_idle", 64'(cfg_interrupt), 64'd0);

    // write counter wraps: 65537 strobes leave it at 1
    bus.pio_write_valid = 1'b1;
    bus.pio_address     = 13'd100;
    repeat (65537) tick();
    bus.pio_write_valid = 1'b0;
    m_wr = (m_wr + 65537) & 16'hFFFF;
    do_read(13'd2, 24'h000A00, counts());
    check("wrap_model", 64'(m_wr), 64'd1);

    repeat (5) tick();
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
